soc_stream_mem_fill: RTL
========================

# soc_stream_mem_fill

Avalon-ST to Avalon-MM write master that fills the SoC on-chip data memory (32768 x 32-bit words, single port, zero wait states) from a 32-bit streaming source. It sits directly upstream of the memory's write port and drives its address, byteenable, chipselect, write, writedata and clken inputs. Software sets it up through a small CSR slave. It raises an interrupt when a programmed block of words has been committed to memory.

## Interface
- ADDR_W, 15: memory word-address width.
- FIFO_DEPTH, 8: stream buffer depth in words; must be a power of 2 and at least 2.
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- csr_address  in  3  CSR word select.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_read  in  1  CSR read strobe.
- csr_readdata  out  32  CSR read data, registered.
- snk_valid  in  1  stream word valid.
- snk_data  in  32  stream word.
- snk_ready  out  1  stream ready.
- mem_address  out  ADDR_W  memory word address.
- mem_byteenable  out  4  always 4'hF.
- mem_chipselect  out  1  memory select.
- mem_write  out  1  memory write strobe; equals mem_chipselect.
- mem_writedata  out  32  memory write data.
- mem_clken  out  1  tied to 1.
- irq  out  1  level interrupt.

## Operation
- CSR map:
  - 0 START, bits [14:0].
  - 1 LENGTH, bits [16:0]; writes above 32768 saturate to 32768.
  - 2 CONTROL (write-only pulses): bit0 GO, bit1 ABORT. Bit2 IRQ_EN is stored.
  - 3 STATUS: bit0 BUSY, bit1 DONE, bit2 WRAPPED, bit3 ABORTED. Writing 1 to bits 1..3 clears them.
  - 4 CHECKSUM (see Configuration). Unmapped addresses read 0.
- FSM states:
  - IDLE: on GO with LENGTH != 0, go to RUN. Load addr = START; clear accepted/written counters, WRAPPED and ABORTED. GO with LENGTH = 0 sets DONE and stays in IDLE.
  - RUN: snk_ready = FIFO not full AND accepted < LENGTH. A beat is accepted when snk_valid && snk_ready and pushed into the FIFO. When the FIFO is not empty, pop one word per cycle and drive mem_chipselect=1, mem_address=addr, mem_writedata=word; then addr++ and written++.
  - Completion: when written reaches LENGTH, go to IDLE and set DONE.
  - ABORT in RUN: flush the FIFO, go to IDLE, set ABORTED. DONE is not set.
- Address arithmetic: ADDR_W-bit modulo. An increment from 32767 wraps to 0 and sets WRAPPED.
- Writes to START, LENGTH or GO while BUSY are ignored. ABORT in IDLE is ignored.
- If a STATUS write-1-to-clear of DONE lands in the same cycle DONE is set, the set wins.
- irq = DONE & IRQ_EN.

## Timing
- Reset values: snk_ready=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, csr_readdata=0, irq=0. All CSRs read 0, FSM is in IDLE, FIFO is empty. mem_byteenable=4'hF and mem_clken=1 at all times.
- GO written at cycle N: BUSY=1 and snk_ready may assert at N+1.
- A beat accepted at cycle M is written to memory at M+1 at the earliest (registered FIFO output). Sustained throughput is 1 word/cycle.
- The last memory write occurs at cycle K: BUSY=0 and DONE=1 at K+1; irq rises at K+1 if IRQ_EN.
- csr_readdata is valid the cycle after csr_read.
- The FIFO supports simultaneous push and pop: full and empty do not change, and no beat is lost.
- snk_ready drops in the same cycle the FIFO becomes full, and in the cycle after the LENGTH-th beat is accepted.
- reset_n asserted mid-operation: all state returns to reset values immediately. mem_chipselect deasserts asynchronously.

## Configuration
- Macro SOC_MEM_FILL_CHECKSUM_EN:
  - Defined: CSR 4 holds a 32-bit running sum (modulo 2^32) of every word written to memory. It is cleared on GO, and a write to CSR 4 clears it in IDLE.
  - Undefined: no checksum logic is built, and CSR 4 reads 0.

## Test plan
- START=0x0010, LENGTH=4, IRQ_EN=1, stream 0xA0..0xA3 back-to-back. Required: memory writes at 0x10..0x13 on consecutive cycles; DONE=1 and irq=1 the cycle after the last write; checksum = 0x286.
- START=0x7FFE, LENGTH=3. Required: writes at 0x7FFE, 0x7FFF, 0x0000; STATUS = 0x6.
- Hold snk_valid high for 12 beats with LENGTH=12 and FIFO_DEPTH=8. Required: no beat lost and snk_ready never high while the FIFO is full; after the 12th beat snk_ready=0 even if snk_valid stays high.
- LENGTH=10, ABORT after 5 memory writes. Required: no further mem_write, BUSY=0, STATUS=0x8, irq=0; a subsequent GO works normally.
- GO with LENGTH=0: DONE=1 and no memory writes. A START write while BUSY leaves the register unchanged.
- Assert reset_n low mid-RUN. Required: mem_chipselect=0 immediately and all CSRs read 0 after release.

Source files
------------

// File: rtl/soc_stream_mem_fill.sv
// Avalon-ST to Avalon-MM write master filling the on-chip data memory from a stream, set up via CSRs.
// Optional running checksum of written words in CSR 4 when SOC_MEM_FILL_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module soc_stream_mem_fill #(
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        csr_address,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    input  logic              snk_valid,
    input  logic [31:0]       snk_data,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              irq
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PTR_W:0]   FULL_CNT = FIFO_DEPTH[PTR_W:0];

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] start_reg;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  length_reg;
    logic [LEN_W-1:0]  accepted;
    logic [LEN_W-1:0]  written;
    logic              irq_en;
    logic              done;
    logic              wrapped;
    logic              aborted;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              busy;
    logic              ctrl_wr;
    logic              status_wr;
    logic              cfg_wr;
    logic              go_start;
    logic              go_empty;
    logic              abort_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              complete;
    logic [16:0]       len_field;
    logic [LEN_W-1:0]  len_sat;
    logic [31:0]       checksum_rd;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign busy       = (state == S_RUN);
    assign cfg_wr     = csr_write && !busy;
    assign ctrl_wr    = csr_write && (csr_address == 3'd2);
    assign status_wr  = csr_write && (csr_address == 3'd3);
    assign go_start   = ctrl_wr && csr_writedata[0] && !busy && (length_reg != '0);
    assign go_empty   = ctrl_wr && csr_writedata[0] && !busy && (length_reg == '0);
    assign abort_req  = ctrl_wr && csr_writedata[1] && busy;

    assign len_field  = csr_writedata[16:0];
    assign len_sat    = (len_field > 17'(MAX_LEN)) ? MAX_LEN : LEN_W'(len_field);
    assign unused_wdata = ^csr_writedata[31:17];

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // An ABORT cycle neither accepts nor writes, so nothing slips past the flush.
    assign snk_ready  = busy && !fifo_full && (accepted < length_reg) && !abort_req;
    assign push       = snk_valid && snk_ready;
    assign pop        = busy && !fifo_empty && !abort_req;
    assign complete   = pop && ((written + LEN_W'(1)) == length_reg);

    // Write port is driven straight from the FIFO head, so reset drops it without waiting for a clock.
    assign mem_chipselect = pop;
    assign mem_write      = pop;
    assign mem_address    = addr;
    assign mem_writedata  = pop ? fifo_mem[rd_ptr] : '0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign irq            = done & irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_reg  <= '0;
            length_reg <= '0;
            irq_en     <= 1'b0;
        end else begin
            if (cfg_wr && csr_address == 3'd0) start_reg  <= csr_writedata[ADDR_W-1:0];
            if (cfg_wr && csr_address == 3'd1) length_reg <= len_sat;
            if (ctrl_wr)                       irq_en     <= csr_writedata[2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            addr     <= '0;
            accepted <= '0;
            written  <= '0;
        end else if (go_start) begin
            state    <= S_RUN;
            addr     <= start_reg;
            accepted <= '0;
            written  <= '0;
        end else if (busy) begin
            if (push) accepted <= accepted + LEN_W'(1);
            if (pop) begin
                addr    <= addr + ADDR_W'(1);
                written <= written + LEN_W'(1);
            end
            if (abort_req || complete) state <= S_IDLE;
        end
    end

    // Status sticky bits: a set event in the same cycle as write-1-to-clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done    <= 1'b0;
            wrapped <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (go_empty || complete)             done <= 1'b1;
            else if (status_wr && csr_writedata[1]) done <= 1'b0;

            if (go_start)                           wrapped <= 1'b0;
            else if (pop && addr == '1)             wrapped <= 1'b1;
            else if (status_wr && csr_writedata[2]) wrapped <= 1'b0;

            if (go_start)                           aborted <= 1'b0;
            else if (abort_req)                     aborted <= 1'b1;
            else if (status_wr && csr_writedata[3]) aborted <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; count/pointers decide what is valid, so contents never leak out.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= snk_data;
    end

`ifdef SOC_MEM_FILL_CHECKSUM_EN
    logic [31:0] checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (go_start || go_empty || (cfg_wr && csr_address == 3'd4)) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + mem_writedata;
        end
    end

    assign checksum_rd = checksum;
`else
    assign checksum_rd = '0;
`endif

    // NOTE: default assignment first keeps this combinational mux from inferring a latch.
    always_comb begin
        rd_mux = '0;
        case (csr_address)
            3'd0:    rd_mux = 32'(start_reg);
            3'd1:    rd_mux = 32'(length_reg);
            3'd2:    rd_mux = {29'd0, irq_en, 2'b00};
            3'd3:    rd_mux = {28'd0, aborted, wrapped, done, busy};
            3'd4:    rd_mux = checksum_rd;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            csr_readdata <= rd_mux;
        end
    end

endmodule
